dmem_arbiter: RTL and testbench

Sequencer and arbiter for the 64-word data memory. After reset it runs a clear sweep that zeroes every word. It then shares the single memory port between two requesters: the CPU load/store path (read/write) and the VGA pixel fetch path (read-only). The CPU has fixed priority, and a wait counter bounds how long the VGA port can be starved. The block sits between both requesters and the data memory's address, data, enable and read-data pins.

---
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data memory sequencer: clears every word after reset, then shares the single
// memory port between the CPU (fixed priority) and the VGA fetch path (starvation bounded).
//
// state | meaning
// INIT  | clear sweep, one zero word written per cycle, no grants
// RUN   | arbitrate CPU/VGA requests onto the memory port
module dmem_arbiter #(
    parameter int DW       = 16,
    parameter int AW       = 12,
    parameter int DEPTH    = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_gnt,
    output logic [DW-1:0] vga_rdata,
    output logic          vga_rvalid,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data,
    output logic          mem_write_enable,
    output logic          mem_read_enable,
    input  logic [DW-1:0] mem_read_data,
    output logic          init_done
);

    localparam int IW = $clog2(DEPTH);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t        state;
    logic [IW-1:0] clr_ptr;
    logic [WW-1:0] wait_cnt;
    logic          starved;

    // Upper address bits are intentionally dropped: addresses wrap modulo DEPTH.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[AW-1:IW], vga_addr[AW-1:IW]};

    assign starved = (wait_cnt >= WW'(MAX_WAIT));

    // Reset gates every port output so the memory sees no activity while rst is low.
    always_comb begin
        cpu_gnt          = 1'b0;
        vga_gnt          = 1'b0;
        mem_address      = '0;
        mem_data         = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        if (rst) begin
            if (state == INIT) begin
                mem_address      = AW'(clr_ptr);
                mem_write_enable = 1'b1;
            end else begin
                vga_gnt = vga_req & (~cpu_req | starved);
                cpu_gnt = cpu_req & ~vga_gnt;
                if (vga_gnt) begin
                    mem_address     = AW'(vga_addr[IW-1:0]);
                    mem_read_enable = 1'b1;
                end else if (cpu_gnt) begin
                    mem_address = AW'(cpu_addr[IW-1:0]);
                    if (cpu_we) begin
                        mem_write_enable = 1'b1;
                        mem_data         = cpu_wdata;
                    end else begin
                        mem_read_enable = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= INIT;
            clr_ptr    <= '0;
            init_done  <= 1'b0;
            wait_cnt   <= '0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            vga_rdata  <= '0;
            vga_rvalid <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    clr_ptr    <= clr_ptr + 1'b1;
                    wait_cnt   <= '0;
                    cpu_rvalid <= 1'b0;
                    vga_rvalid <= 1'b0;
                    if (clr_ptr == IW'(DEPTH - 1)) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    cpu_rvalid <= cpu_gnt & ~cpu_we;
                    if (cpu_gnt && !cpu_we) begin
                        cpu_rdata <= mem_read_data;
                    end
                    vga_rvalid <= vga_gnt;
                    if (vga_gnt) begin
                        vga_rdata <= mem_read_data;
                    end
                    if (vga_req && !vga_gnt) begin
                        if (~&wait_cnt) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural memory/arbitration model predicts grants,
// port drive and read data for directed and randomised traffic.
module tb_dmem_arbiter;

    localparam int DW       = 16;
    localparam int AW       = 12;
    localparam int DEPTH    = 64;
    localparam int IW       = 6;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic          vga_req = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic          vga_gnt;
    logic [DW-1:0] vga_rdata;
    logic          vga_rvalid;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_write_enable;
    logic          mem_read_enable;
    logic [DW-1:0] mem_read_data;
    logic          init_done;

    dmem_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_read_data(mem_read_data), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Physical memory attached to the DUT port
    logic [DW-1:0] ram [DEPTH];
    assign mem_read_data = ram[mem_address[IW-1:0]];
    always @(posedge clk) begin
        if (mem_write_enable) ram[mem_address[IW-1:0]] <= mem_data;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] exp_crd, exp_vrd;
    bit            exp_crv, exp_vrv;
    int            starve;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input bit clear_mem);
        exp_crd = '0;
        exp_vrd = '0;
        exp_crv = 1'b0;
        exp_vrv = 1'b0;
        starve  = 0;
        if (clear_mem) for (int k = 0; k < DEPTH; k++) exp_mem[k] = '0;
    endtask

    // One RUN cycle, entered and left at a falling edge.
    task automatic do_cycle(input bit creq, input bit cwe, input logic [AW-1:0] ca,
                            input logic [DW-1:0] cd, input bit vreq, input logic [AW-1:0] va,
                            output bit gv);
        bit cg, vg;
        int cidx, vidx;
        cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
        vga_req = vreq; vga_addr = va;
        cidx = int'(ca) % DEPTH;
        vidx = int'(va) % DEPTH;
        vg = vreq && (!creq || starve >= MAX_WAIT);
        cg = creq && !vg;
        #1;
        check("cpu_gnt", 32'(cpu_gnt), 32'(cg));
        check("vga_gnt", 32'(vga_gnt), 32'(vg));
        check("mem_address", 32'(mem_address), vg ? 32'(vidx) : (cg ? 32'(cidx) : 32'd0));
        check("mem_we", 32'(mem_write_enable), 32'(cg && cwe));
        check("mem_re", 32'(mem_read_enable), 32'(vg || (cg && !cwe)));
        if (!vg && !(cg && !cwe))
            check("mem_data", 32'(mem_data), (cg && cwe) ? 32'(cd) : 32'd0);
        @(posedge clk);
        exp_crv = cg && !cwe;
        if (exp_crv) exp_crd = exp_mem[cidx];
        if (cg && cwe) exp_mem[cidx] = cd;
        exp_vrv = vg;
        if (vg) exp_vrd = exp_mem[vidx];
        starve = (vreq && !vg) ? starve + 1 : 0;
        #1;
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_crv));
        check("cpu_rdata", 32'(cpu_rdata), 32'(exp_crd));
        check("vga_rvalid", 32'(vga_rvalid), 32'(exp_vrv));
        check("vga_rdata", 32'(vga_rdata), 32'(exp_vrd));
        gv = vg;
        @(negedge clk);
    endtask

    // n sweep cycles from address start, with random (ignored) requests.
    task automatic sweep_check(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            cpu_req  = 1'($urandom_range(0, 1));
            cpu_we   = 1'($urandom_range(0, 1));
            cpu_addr = AW'($urandom);
            vga_req  = 1'($urandom_range(0, 1));
            vga_addr = AW'($urandom);
            #1;
            check("sweep_addr", 32'(mem_address), 32'(start + i));
            check("sweep_we", 32'(mem_write_enable), 32'd1);
            check("sweep_re", 32'(mem_read_enable), 32'd0);
            check("sweep_data", 32'(mem_data), 32'd0);
            check("sweep_gnt", 32'({cpu_gnt, vga_gnt}), 32'd0);
            check("sweep_init_done", 32'(init_done), 32'd0);
            @(negedge clk);
        end
        cpu_req = 1'b0;
        vga_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_outs"}, 32'({cpu_gnt, vga_gnt, mem_write_enable, mem_read_enable}), 32'd0);
        check({tag, "_addr"}, 32'(mem_address), 32'd0);
        check({tag, "_data"}, 32'(mem_data), 32'd0);
        check({tag, "_init_done"}, 32'(init_done), 32'd0);
        check({tag, "_rvalid"}, 32'({cpu_rvalid, vga_rvalid}), 32'd0);
        check({tag, "_rdata"}, 32'({cpu_rdata, vga_rdata}), 32'd0);
    endtask

    initial begin
        bit gv;
        #2;
        rst = 1'b0;
        cpu_req = 1'b1;
        vga_req = 1'b1;
        #1;
        check_in_reset("reset");
        @(negedge clk);
        rst = 1'b1;
        sweep_check(0, DEPTH);
        check("init_done_after_sweep", 32'(init_done), 32'd1);
        model_reset(1'b1);

        // CPU write then read back
        do_cycle(1'b1, 1'b1, 12'd5, 16'hBEEF, 1'b0, '0, gv);
        do_cycle(1'b1, 1'b0, 12'd5, 16'h0000, 1'b0, '0, gv);
        check("cpu_read_beef", 32'(cpu_rdata), 32'hBEEF);

        // Continuous contention: CPU x4, VGA x1 repeating
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b1, 1'b0, AW'($urandom), '0, 1'b1, AW'($urandom), gv);
            check("starve_pattern", 32'(gv), 32'(i % 5 == 4));
        end
        do_cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, gv);

        // VGA address wraps modulo depth
        do_cycle(1'b0, 1'b0, '0, '0, 1'b1, 12'h045, gv);
        check("vga_wrap_rdata", 32'(vga_rdata), 32'hBEEF);

        for (int i = 0; i < 400; i++)
            do_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), AW'($urandom),
                     DW'($urandom), 1'($urandom_range(0, 2) != 0), AW'($urandom), gv);

        // Reset during a granted CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd5; vga_req = 1'b0;
        #1;
        check("rst_run_gnt_before", 32'(cpu_gnt), 32'd1);
        @(posedge clk);
        #1;
        check("rst_run_rvalid_before", 32'(cpu_rvalid), 32'd1);
        check("rst_run_rdata_before", 32'(cpu_rdata), 32'(exp_mem[5]));
        rst = 1'b0;
        #1;
        check_in_reset("rst_run");
        @(negedge clk);
        rst = 1'b1;
        sweep_check(0, DEPTH);
        check("init_done_after_rerun", 32'(init_done), 32'd1);
        model_reset(1'b1);
        for (int i = 0; i < 40; i++)
            do_cycle(1'($urandom_range(0, 1)), 1'b0, AW'($urandom), '0,
                     1'($urandom_range(0, 1)), AW'($urandom), gv);

        // Reset mid-sweep at clr_ptr = 30
        rst = 1'b0;
        #1;
        check_in_reset("rst_pre");
        @(negedge clk);
        rst = 1'b1;
        sweep_check(0, 30);
        rst = 1'b0;
        #1;
        check_in_reset("rst_mid_sweep");
        @(negedge clk);
        rst = 1'b1;
        sweep_check(0, DEPTH);
        check("init_done_after_restart", 32'(init_done), 32'd1);
        model_reset(1'b1);
        for (int i = 0; i < 60; i++)
            do_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), AW'($urandom),
                     DW'($urandom), 1'($urandom_range(0, 2) != 0), AW'($urandom), gv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
